// File: rtl/core_id_pipe_pkg.sv
// Shared RV32I decode constants, the ALU operation encoding and the
// funct3-to-ALU mapping used by the ID stage.
package core_id_pipe_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;

  // alt selects SUB/SRA; callers only raise it where funct7 is meaningful
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/core_decode_comb.sv
// Combinational RV32I field extraction, immediate generation,
// ALU operand selection and illegal-instruction detection.
module core_decode_comb
  import core_id_pipe_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1d_i,
  input  logic [XLEN-1:0] rs2d_i,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            rs1_used_o,
  output logic            rs2_used_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output alu_op_e         alu_op_o,
  output logic            reg_we_o,
  output logic            mem_re_o,
  output logic            mem_we_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            illegal_o
);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign f7    = inst_i[31:25];
  assign rd_o  = inst_i[11:7];
  assign rs1_o = inst_i[19:15];
  assign rs2_o = inst_i[24:20];

  assign imm_i = XLEN'($signed(inst_i[31:20]));
  assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

  always_comb begin
    imm_o      = '0;
    op1_o      = '0;
    op2_o      = '0;
    alu_op_o   = ALU_ADD;
    reg_we_o   = 1'b0;
    mem_re_o   = 1'b0;
    mem_we_o   = 1'b0;
    branch_o   = 1'b0;
    jump_o     = 1'b0;
    illegal_o  = 1'b0;
    rs1_used_o = 1'b1;
    rs2_used_o = 1'b0;
    case (opc)
      OPC_OP: begin
        op1_o      = rs1d_i;
        op2_o      = rs2d_i;
        reg_we_o   = 1'b1;
        rs2_used_o = 1'b1;
        alu_op_o   = alu_from_f3(f3, f7[5]);
        if (f7 != F7_ZERO && f7 != F7_ALT) illegal_o = 1'b1;
        if (f7 == F7_ALT && f3 != F3_ADD && f3 != F3_SR) illegal_o = 1'b1;
      end
      OPC_OP_IMM: begin
        op1_o    = rs1d_i;
        imm_o    = imm_i;
        reg_we_o = 1'b1;
        alu_op_o = alu_from_f3(f3, (f3 == F3_SR) && f7[5]);
        // shift amount is the low five immediate bits, upper bits are funct7
        op2_o    = (f3 == F3_SLL || f3 == F3_SR) ? XLEN'(inst_i[24:20]) : imm_i;
        if (f3 == F3_SLL && f7 != F7_ZERO) illegal_o = 1'b1;
        if (f3 == F3_SR && f7 != F7_ZERO && f7 != F7_ALT) illegal_o = 1'b1;
      end
      OPC_LOAD: begin
        op1_o = rs1d_i; op2_o = imm_i; imm_o = imm_i;
        mem_re_o = 1'b1; reg_we_o = 1'b1;
      end
      OPC_STORE: begin
        op1_o = rs1d_i; op2_o = imm_s; imm_o = imm_s;
        mem_we_o = 1'b1; rs2_used_o = 1'b1;
      end
      OPC_BRANCH: begin
        op1_o = rs1d_i; op2_o = rs2d_i; imm_o = imm_b;
        branch_o = 1'b1; rs2_used_o = 1'b1;
        case (f3)
          F3_BLT, F3_BGE:   alu_op_o = ALU_SLT;
          F3_BLTU, F3_BGEU: alu_op_o = ALU_SLTU;
          default:          alu_op_o = ALU_SUB;
        endcase
      end
      OPC_LUI: begin
        op2_o = imm_u; imm_o = imm_u; alu_op_o = ALU_PASS;
        reg_we_o = 1'b1; rs1_used_o = 1'b0;
      end
      OPC_AUIPC: begin
        op1_o = pc_i; op2_o = imm_u; imm_o = imm_u;
        reg_we_o = 1'b1; rs1_used_o = 1'b0;
      end
      OPC_JAL: begin
        op1_o = pc_i; op2_o = XLEN'(4); imm_o = imm_j;
        jump_o = 1'b1; reg_we_o = 1'b1; rs1_used_o = 1'b0;
      end
      OPC_JALR: begin
        op1_o = pc_i; op2_o = XLEN'(4); imm_o = imm_i;
        jump_o = 1'b1; reg_we_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
    if (rd_o == 5'd0) reg_we_o = 1'b0;
    if (illegal_o) begin
      reg_we_o = 1'b0; mem_re_o = 1'b0; mem_we_o = 1'b0;
      branch_o = 1'b0; jump_o   = 1'b0;
    end
  end

endmodule

// File: rtl/core_id_pipe.sv
// RV32I decode stage: load-use hazard bubbles, ID/EX register with
// valid/ready handshake and flush, saturating stall-cycle counter.
module core_id_pipe
  import core_id_pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            inst_in,
  input  logic [XLEN-1:0]        inst_addr_in,
  output logic [REG_ADDR_W-1:0]  rs1_addr_out,
  output logic [REG_ADDR_W-1:0]  rs2_addr_out,
  input  logic [XLEN-1:0]        read_reg1_data_in,
  input  logic [XLEN-1:0]        read_reg2_data_in,
  input  logic                   ex_load_pending_in,
  input  logic [REG_ADDR_W-1:0]  ex_load_rd_in,
  input  logic                   flush_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            inst_out,
  output logic [XLEN-1:0]        inst_addr_out,
  output logic                   reg_we_out,
  output logic [REG_ADDR_W-1:0]  reg_write_addr_out,
  output logic [XLEN-1:0]        reg1_data_out,
  output logic [XLEN-1:0]        reg2_data_out,
  output logic [XLEN-1:0]        opnum1_out,
  output logic [XLEN-1:0]        opnum2_out,
  output logic [XLEN-1:0]        imm_out,
  output logic [3:0]             alu_op_out,
  output logic                   mem_re_out,
  output logic                   mem_we_out,
  output logic                   branch_out,
  output logic                   jump_out,
  output logic                   illegal_out,
  output logic [STALL_CNT_W-1:0] stall_count_out
);

  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic            d_rs1_used, d_rs2_used;
  logic [XLEN-1:0] d_imm, d_op1, d_op2;
  alu_op_e         d_alu;
  logic            d_we, d_re, d_wr, d_br, d_jmp, d_ill;

  core_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst_i(inst_in), .pc_i(inst_addr_in),
    .rs1d_i(read_reg1_data_in), .rs2d_i(read_reg2_data_in),
    .rs1_o(d_rs1), .rs2_o(d_rs2), .rd_o(d_rd),
    .rs1_used_o(d_rs1_used), .rs2_used_o(d_rs2_used),
    .imm_o(d_imm), .op1_o(d_op1), .op2_o(d_op2), .alu_op_o(d_alu),
    .reg_we_o(d_we), .mem_re_o(d_re), .mem_we_o(d_wr),
    .branch_o(d_br), .jump_o(d_jmp), .illegal_o(d_ill)
  );

  logic stall, advance, hit1, hit2;
  logic vld_q, vld_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  assign rs1_addr_out = REG_ADDR_W'(d_rs1);
  assign rs2_addr_out = REG_ADDR_W'(d_rs2);
  assign hit1    = d_rs1_used && (REG_ADDR_W'(d_rs1) == ex_load_rd_in);
  assign hit2    = d_rs2_used && (REG_ADDR_W'(d_rs2) == ex_load_rd_in);
  assign stall   = in_valid && ex_load_pending_in && (ex_load_rd_in != '0) && (hit1 || hit2);
  assign advance = !vld_q || out_ready;
  assign in_ready = advance && !stall && !flush_in;

  always_comb begin
    vld_d = vld_q;
    if (flush_in)     vld_d = 1'b0;
    else if (advance) vld_d = in_valid && !stall;
    cnt_d = cnt_q;
    if (stall && advance && !flush_in && cnt_q != '1) cnt_d = cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0; cnt_q <= '0;
      inst_out <= INST_NOP; inst_addr_out <= '0;
      reg_we_out <= 1'b0; reg_write_addr_out <= '0;
      reg1_data_out <= '0; reg2_data_out <= '0;
      opnum1_out <= '0; opnum2_out <= '0; imm_out <= '0; alu_op_out <= '0;
      mem_re_out <= 1'b0; mem_we_out <= 1'b0;
      branch_out <= 1'b0; jump_out <= 1'b0; illegal_out <= 1'b0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      // payload follows the decode whenever the slot is free; out_valid qualifies it
      if (advance) begin
        inst_out <= inst_in; inst_addr_out <= inst_addr_in;
        reg_we_out <= d_we; reg_write_addr_out <= REG_ADDR_W'(d_rd);
        reg1_data_out <= read_reg1_data_in; reg2_data_out <= read_reg2_data_in;
        opnum1_out <= d_op1; opnum2_out <= d_op2; imm_out <= d_imm; alu_op_out <= d_alu;
        mem_re_out <= d_re; mem_we_out <= d_wr;
        branch_out <= d_br; jump_out <= d_jmp; illegal_out <= d_ill;
      end
    end
  end

  assign out_valid       = vld_q;
  assign stall_count_out = cnt_q;

endmodule

// File: tb/tb_core_id_pipe.sv
// Scoreboard bench for core_id_pipe: expected ID/EX contents are queued at
// accept and compared every cycle the output register holds a valid entry.
module tb_core_id_pipe;
  import core_id_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, flush_in, out_valid, out_ready;
  logic [31:0] inst_in, inst_addr_in, rd1, rd2, inst_out, inst_addr_out;
  logic [4:0]  rs1_addr_out, rs2_addr_out, ex_load_rd_in, reg_write_addr_out;
  logic        ex_load_pending_in, reg_we_out, mem_re_out, mem_we_out;
  logic        branch_out, jump_out, illegal_out;
  logic [31:0] reg1_data_out, reg2_data_out, opnum1_out, opnum2_out, imm_out;
  logic [3:0]  alu_op_out;
  logic [15:0] stall_count_out;

  core_id_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_in(inst_in), .inst_addr_in(inst_addr_in),
    .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out),
    .read_reg1_data_in(rd1), .read_reg2_data_in(rd2),
    .ex_load_pending_in(ex_load_pending_in), .ex_load_rd_in(ex_load_rd_in),
    .flush_in(flush_in), .out_valid(out_valid), .out_ready(out_ready),
    .inst_out(inst_out), .inst_addr_out(inst_addr_out),
    .reg_we_out(reg_we_out), .reg_write_addr_out(reg_write_addr_out),
    .reg1_data_out(reg1_data_out), .reg2_data_out(reg2_data_out),
    .opnum1_out(opnum1_out), .opnum2_out(opnum2_out), .imm_out(imm_out),
    .alu_op_out(alu_op_out), .mem_re_out(mem_re_out), .mem_we_out(mem_we_out),
    .branch_out(branch_out), .jump_out(jump_out), .illegal_out(illegal_out),
    .stall_count_out(stall_count_out)
  );

  // flags = {reg_we, mem_re, mem_we, branch, jump, illegal}
  typedef struct {
    logic [31:0] inst, pc, r1, r2, op1, op2, imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [5:0]  flags;
  } exp_t;

  exp_t q[$];
  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] inst, pc, r1, r2, op1, op2, imm,
                              input logic [3:0] alu, input logic [5:0] fl);
    exp_t e;
    e.inst = inst; e.pc = pc; e.r1 = r1; e.r2 = r2;
    e.op1 = op1; e.op2 = op2; e.imm = imm;
    e.rd = inst[11:7]; e.alu = alu; e.flags = fl;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("unexpected_out", {31'b0, out_valid}, 32'd0);
      else begin
        exp_t e;
        e = q[0];
        chk("inst", inst_out, e.inst);
        chk("pc", inst_addr_out, e.pc);
        chk("rd", {27'b0, reg_write_addr_out}, {27'b0, e.rd});
        chk("reg1", reg1_data_out, e.r1);
        chk("reg2", reg2_data_out, e.r2);
        chk("opnum1", opnum1_out, e.op1);
        chk("opnum2", opnum2_out, e.op2);
        chk("imm", imm_out, e.imm);
        chk("alu", {28'b0, alu_op_out}, {28'b0, e.alu});
        chk("flags", {26'b0, reg_we_out, mem_re_out, mem_we_out, branch_out, jump_out, illegal_out},
            {26'b0, e.flags});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] inst, pc, r1, r2, input exp_t e);
    int n = 0;
    in_valid = 1'b1; inst_in = inst; inst_addr_in = pc; rd1 = r1; rd2 = r2;
    forever begin
      @(negedge clk);
      if (in_ready) begin q.push_back(e); break; end
      n++;
      if (n > 20) begin chk("accept_timeout", {31'b0, in_ready}, 32'd1); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst_in = '0; inst_addr_in = '0; rd1 = '0; rd2 = '0;
    ex_load_pending_in = 1'b0; ex_load_rd_in = '0; flush_in = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_inst", inst_out, 32'h0000_0013);
    chk("rst_cnt", {16'b0, stall_count_out}, 32'd0);
    chk("rst_we", {31'b0, reg_we_out}, 32'd0);
    chk("rst_imm", imm_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // pending load targets the rs2 field of addi, which addi does not read
    ex_load_pending_in = 1'b1; ex_load_rd_in = 5'd27;
    inst_in = 32'hFFB10093; #1;
    chk("rs1_addr", {27'b0, rs1_addr_out}, 32'd2);
    chk("rs2_addr", {27'b0, rs2_addr_out}, 32'd27);
    send(32'hFFB10093, 32'h100, 32'd7, 32'hDEADBEEF,
         mk(32'hFFB10093, 32'h100, 32'd7, 32'hDEADBEEF, 32'd7, 32'hFFFFFFFB, 32'hFFFFFFFB, ALU_ADD, 6'b100000));
    chk("lat_valid", {31'b0, out_valid}, 32'd1);
    chk("no_false_stall", {16'b0, stall_count_out}, 32'd0);
    ex_load_pending_in = 1'b0;

    send(32'hFE208EE3, 32'h104, 32'd5, 32'd5,
         mk(32'hFE208EE3, 32'h104, 32'd5, 32'd5, 32'd5, 32'd5, 32'hFFFFFFFC, ALU_SUB, 6'b000100));
    send(32'h123452B7, 32'h108, 32'h11, 32'h22,
         mk(32'h123452B7, 32'h108, 32'h11, 32'h22, 32'd0, 32'h12345000, 32'h12345000, ALU_PASS, 6'b100000));
    send(32'h0020A423, 32'h10C, 32'h1000, 32'h55,
         mk(32'h0020A423, 32'h10C, 32'h1000, 32'h55, 32'h1000, 32'd8, 32'd8, ALU_ADD, 6'b001000));
    send(32'h010000EF, 32'h110, 32'h1, 32'h2,
         mk(32'h010000EF, 32'h110, 32'h1, 32'h2, 32'h110, 32'd4, 32'd16, ALU_ADD, 6'b100010));
    send(32'h40225193, 32'h114, 32'h80000000, 32'h3,
         mk(32'h40225193, 32'h114, 32'h80000000, 32'h3, 32'h80000000, 32'd2, 32'h402, ALU_SRA, 6'b100000));
    send(32'h0040A183, 32'h118, 32'h2000, 32'h4,
         mk(32'h0040A183, 32'h118, 32'h2000, 32'h4, 32'h2000, 32'd4, 32'd4, ALU_ADD, 6'b110000));
    send(32'hFFFFFFFF, 32'h11C, 32'h5, 32'h6,
         mk(32'hFFFFFFFF, 32'h11C, 32'h5, 32'h6, 32'd0, 32'd0, 32'd0, ALU_ADD, 6'b000001));
    send(32'h02518233, 32'h120, 32'h1, 32'h2,
         mk(32'h02518233, 32'h120, 32'h1, 32'h2, 32'h1, 32'h2, 32'd0, ALU_ADD, 6'b000001));
    send(32'h00000013, 32'h124, 32'h0, 32'h0,
         mk(32'h00000013, 32'h124, 32'h0, 32'h0, 32'd0, 32'd0, 32'd0, ALU_ADD, 6'b000000));

    // load-use: add x4,x3,x5 behind a load to x3
    ex_load_pending_in = 1'b1; ex_load_rd_in = 5'd3;
    in_valid = 1'b1; inst_in = 32'h00518233; inst_addr_in = 32'h200; rd1 = 32'd9; rd2 = 32'd10;
    @(negedge clk);
    chk("lu_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("lu_bubble", {31'b0, out_valid}, 32'd0);
    chk("lu_cnt", {16'b0, stall_count_out}, 32'd1);
    ex_load_pending_in = 1'b0;
    send(32'h00518233, 32'h200, 32'd9, 32'd10,
         mk(32'h00518233, 32'h200, 32'd9, 32'd10, 32'd9, 32'd10, 32'd0, ALU_ADD, 6'b100000));

    // backpressure: add held while auipc waits
    out_ready = 1'b0;
    in_valid = 1'b1; inst_in = 32'h00001317; inst_addr_in = 32'h300; rd1 = 32'h77; rd2 = 32'h88;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h00001317, 32'h300, 32'h77, 32'h88,
         mk(32'h00001317, 32'h300, 32'h77, 32'h88, 32'h300, 32'h1000, 32'h1000, ALU_ADD, 6'b100000));
    chk("bp_next_inst", inst_out, 32'h00001317);

    // flush while the auipc is stalled downstream; jalr must not be consumed
    out_ready = 1'b0;
    in_valid = 1'b1; inst_in = 32'h000100E7; inst_addr_in = 32'h400; rd1 = 32'h9; rd2 = 32'h8;
    flush_in = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    void'(q.pop_front());
    flush_in = 1'b0; out_ready = 1'b1;
    send(32'h000100E7, 32'h400, 32'h9, 32'h8,
         mk(32'h000100E7, 32'h400, 32'h9, 32'h8, 32'h400, 32'd4, 32'd0, ALU_ADD, 6'b100010));
    chk("fl_cnt", {16'b0, stall_count_out}, 32'd1);

    // asynchronous reset between clock edges
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_inst", inst_out, 32'h0000_0013);
    chk("arst_cnt", {16'b0, stall_count_out}, 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    send(32'hFFB10093, 32'h500, 32'd7, 32'd1,
         mk(32'hFFB10093, 32'h500, 32'd7, 32'd1, 32'd7, 32'hFFFFFFFB, 32'hFFFFFFFB, ALU_ADD, 6'b100000));
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("sb_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
